sin_job_arbiter: RTL

Shares one `sin` accelerator core between two requesters (e.g. two `wr_input`-style loaders) and sequences it. Each client runs a req/ack job handshake. The arbiter picks a winner round-robin, launches the core with a one-cycle `start`, waits for `ready`, and returns `z` with a per-client `done` pulse. A BUSY-cycle watchdog recovers from a hung core.

---
 rtl/sin_job_arbiter_pkg.sv | 22 ++
 rtl/sin_job_arbiter_rr_pick2.sv | 20 ++
 rtl/sin_job_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/sin_job_arbiter_pkg.sv
// Shared definitions for the sin job arbiter: FSM state encoding, default
// operand/result widths and the watchdog counter sizing helper.
package sin_pkg;

  localparam int unsigned SIN_XW = 16;
  localparam int unsigned SIN_YW = 8;
  localparam int unsigned SIN_ZW = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Watchdog counter width: enough bits to hold timeout, never narrower than 1.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    if (timeout == 0) return 1;
    return int'($clog2(timeout + 1));
  endfunction

endpackage

// File: rtl/sin_job_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie the client that was not served last wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       gnt
);

  always_comb begin
    valid = |req;
    gnt   = 1'b0;
    unique case (req)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = ~last;
      default: gnt = 1'b0;
    endcase
  end

endmodule

// File: rtl/sin_job_arbiter.sv
// Shares one sin core between two req/ack clients: round-robin grant, one-cycle
// launch, masked ready capture, per-client done pulse and a BUSY watchdog.
module sin_job_arbiter
  import sin_pkg::*;
#(
  parameter int unsigned XW      = SIN_XW,
  parameter int unsigned YW      = SIN_YW,
  parameter int unsigned ZW      = SIN_ZW,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic [XW-1:0] x0,
  input  logic [XW-1:0] x1,
  input  logic [YW-1:0] y0,
  input  logic [YW-1:0] y1,
  output logic          ack0,
  output logic          ack1,
  output logic          done0,
  output logic          done1,
  output logic [ZW-1:0] zout,
  output logic          err,
  output logic          busy,
  output logic          start,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  input  logic [ZW-1:0] z,
  input  logic          ready
);

  localparam int unsigned    CW      = cnt_width(TIMEOUT);
  localparam logic [CW-1:0]  CNT_MAX = CW'(TIMEOUT);
  localparam bit             WD_EN   = (TIMEOUT != 0);

  state_e        state_q, state_d;
  logic          gnt_q, gnt_d;
  logic          last_q, last_d;
  logic          mask_q, mask_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [ZW-1:0] zout_q, zout_d;
  logic          err_q, err_d;
  logic          start_q, start_d;
  logic          ack0_q, ack0_d, ack1_q, ack1_d;
  logic          done0_q, done0_d, done1_q, done1_d;
  logic          busy_q, busy_d;
  logic          pick_valid, pick_gnt;

  rr_pick2 u_pick (
    .req   ({req1, req0}),
    .last  (last_q),
    .valid (pick_valid),
    .gnt   (pick_gnt)
  );

  // Next-state and registered-output decode.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    zout_d  = zout_q;
    err_d   = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          gnt_d   = pick_gnt;
          x_d     = pick_gnt ? x1 : x0;
          y_d     = pick_gnt ? y1 : y0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        last_d  = gnt_q;
        cnt_d   = '0;
        mask_d  = 1'b1;
        state_d = ST_BUSY;
      end
      ST_BUSY: begin
        mask_d = 1'b0;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
        // A real result beats a watchdog hit landing in the same cycle.
        if (!mask_q && ready) begin
          zout_d  = z;
          state_d = ST_DONE;
        end else if (WD_EN && (cnt_d == CNT_MAX)) begin
          zout_d  = '0;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    start_d = (state_d == ST_ISSUE);
    ack0_d  = start_d && !gnt_d;
    ack1_d  = start_d && gnt_d;
    done0_d = (state_d == ST_DONE) && !gnt_d;
    done1_d = (state_d == ST_DONE) && gnt_d;
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      mask_q  <= 1'b0;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      zout_q  <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      zout_q  <= zout_d;
      err_q   <= err_d;
      start_q <= start_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      busy_q  <= busy_d;
    end
  end

  assign start = start_q;
  assign ack0  = ack0_q;
  assign ack1  = ack1_q;
  assign done0 = done0_q;
  assign done1 = done1_q;
  assign busy  = busy_q;
  assign err   = err_q;
  assign zout  = zout_q;
  assign x     = x_q;
  assign y     = y_q;

endmodule
